// File: rtl/bus_gate_arb.sv
// Round-robin arbiter gating N sources onto one shared tristate bus, with a one-cycle turnaround between owners.
// Optional bus keeper (macro BUS_GATE_KEEPER_EN) holds the last driven value instead of floating the bus.
module bus_gate_arb #(
  parameter int unsigned W        = 16,
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] data_in,
  output logic [N-1:0]   grant,
  output tri   [W-1:0]   bus,
  output logic           turn,
  output logic           busy
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [IW-1:0] PTR_RST   = IW'(N - 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [HW-1:0] hold_cnt;
  logic          found;
  logic [IW-1:0] win;
  logic          others;
  logic          force_rel;
  logic [W-1:0]  sel_data;

  // ptr always names the current/last owner, so it doubles as the bus mux select.
  assign sel_data = data_in[32'(ptr) * W +: W];

  always_comb begin
    int unsigned idx;
    found = 1'b0;
    win   = ptr;
    idx   = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (32'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  // hold_cnt counts completed drive cycles, so release fires at the end of cycle MAX_HOLD.
  assign others    = |(req & ~grant);
  assign force_rel = (MAX_HOLD > 0) && others &&
                     ((hold_cnt == HOLD_LAST) || (hold_cnt == HOLD_SAT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= '0;
      turn     <= 1'b0;
      busy     <= 1'b0;
      ptr      <= PTR_RST;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE, TURN: begin
          turn <= 1'b0;
          if (found) begin
            state    <= DRIVE;
            grant    <= N'(1) << win;
            busy     <= 1'b1;
            ptr      <= win;
            hold_cnt <= '0;
          end else begin
            state <= IDLE;
            grant <= '0;
            busy  <= 1'b0;
          end
        end
        DRIVE: begin
          if (!req[ptr] || force_rel) begin
            state <= TURN;
            grant <= '0;
            busy  <= 1'b0;
            turn  <= 1'b1;
          end else if (hold_cnt != HOLD_SAT) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
          turn  <= 1'b0;
        end
      endcase
    end
  end

`ifdef BUS_GATE_KEEPER_EN
  logic [W-1:0] keep_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    keep_val <= '0;
    else if (busy) keep_val <= sel_data;
  end

  assign bus = busy ? sel_data : keep_val;
`else
  assign bus = busy ? sel_data : 'z;
`endif

endmodule

// File: tb/tb_bus_gate_arb.sv
// Directed scoreboard bench for bus_gate_arb: one instance with unlimited hold, one with MAX_HOLD=2,
// followed by a random request run checking grant exclusivity.
module tb_bus_gate_arb;
  localparam int unsigned W = 16;
  localparam int unsigned N = 4;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_a = '0;
  logic [N-1:0]   req_b = '0;
  logic [N*W-1:0] data_a = {16'hD3D3, 16'h1234, 16'hB1B1, 16'hA0A0};
  logic [N*W-1:0] data_b = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
  logic [N-1:0]   grant_a, grant_b;
  wire  [W-1:0]   bus_a, bus_b;
  logic           turn_a, busy_a, turn_b, busy_b;

  bus_gate_arb #(.W(W), .N(N), .MAX_HOLD(0)) u_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .data_in(data_a),
    .grant(grant_a), .bus(bus_a), .turn(turn_a), .busy(busy_a)
  );

  bus_gate_arb #(.W(W), .N(N), .MAX_HOLD(2)) u_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .data_in(data_b),
    .grant(grant_b), .bus(bus_b), .turn(turn_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned  sel;
    logic [N-1:0] g;
    logic         t;
    logic [W-1:0] b;
    string        tag;
  } exp_t;

  exp_t         q[$];
  int           tests  = 0;
  int           failed = 0;
  logic [W-1:0] last_a = '0;
  logic [W-1:0] last_b = '0;

  function automatic logic [W-1:0] idle_bus(input int unsigned sel);
`ifdef BUS_GATE_KEEPER_EN
    return (sel == 0) ? last_a : last_b;
`else
    return (sel == 0) ? 'z : 'z;
`endif
  endfunction

  task automatic expect_out(input int unsigned sel, input logic [N-1:0] g, input logic t,
                            input string tag);
    exp_t e;
    e.sel = sel;
    e.g   = g;
    e.t   = t;
    e.tag = tag;
    e.b   = idle_bus(sel);
    for (int i = 0; i < N; i++)
      if (g[i]) e.b = (sel == 0) ? data_a[i*W +: W] : data_b[i*W +: W];
    if (g != '0) begin
      if (sel == 0) last_a = e.b;
      else          last_b = e.b;
    end
    q.push_back(e);
  endtask

  task automatic cmp(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
    tests++;
    assert (obs === exp_v)
    else begin
      failed++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic check_q();
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      if (e.sel == 0) begin
        cmp({e.tag, "_grant"}, W'(grant_a), W'(e.g));
        cmp({e.tag, "_turn"},  W'(turn_a),  W'(e.t));
        cmp({e.tag, "_busy"},  W'(busy_a),  W'(|e.g));
        cmp({e.tag, "_bus"},   bus_a,       e.b);
      end else begin
        cmp({e.tag, "_grant"}, W'(grant_b), W'(e.g));
        cmp({e.tag, "_turn"},  W'(turn_b),  W'(e.t));
        cmp({e.tag, "_busy"},  W'(busy_b),  W'(|e.g));
        cmp({e.tag, "_bus"},   bus_b,       e.b);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check_q();
  endtask

  initial begin
    logic [N-1:0] g;
    logic [N-1:0] prev_a, prev_b;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    expect_out(0, 4'b0000, 1'b0, "rst_a");
    expect_out(1, 4'b0000, 1'b0, "rst_b");
    check_q();
    @(negedge clk);
    rst_n = 1'b1;

    // Single request, drop, one turnaround, idle
    req_a = 4'b0100;
    expect_out(0, 4'b0100, 1'b0, "single_drv0"); step();
    expect_out(0, 4'b0100, 1'b0, "single_drv1"); step();
    req_a = 4'b0000;
    expect_out(0, 4'b0000, 1'b1, "single_turn"); step();
    expect_out(0, 4'b0000, 1'b0, "single_idle"); step();

    // Unlimited hold: owner 1 keeps bus while source 3 waits
    req_a = 4'b0010;
    expect_out(0, 4'b0010, 1'b0, "hold_own"); step();
    req_a = 4'b1010;
    expect_out(0, 4'b0010, 1'b0, "hold_keep0"); step();
    expect_out(0, 4'b0010, 1'b0, "hold_keep1"); step();
    req_a = 4'b1000;
    expect_out(0, 4'b0000, 1'b1, "hold_turn"); step();
    expect_out(0, 4'b1000, 1'b0, "hold_next"); step();
    req_a = 4'b0000;
    expect_out(0, 4'b0000, 1'b1, "hold_turn2"); step();
    expect_out(0, 4'b0000, 1'b0, "hold_idle"); step();

    // Owner re-requesting during turnaround yields to the other requester
    req_a = 4'b0001;
    expect_out(0, 4'b0001, 1'b0, "rereq_own"); step();
    req_a = 4'b0000;
    expect_out(0, 4'b0000, 1'b1, "rereq_turn"); step();
    req_a = 4'b0011;
    expect_out(0, 4'b0010, 1'b0, "rereq_win"); step();
    req_a = 4'b0000;
    expect_out(0, 4'b0000, 1'b1, "rereq_turn2"); step();
    expect_out(0, 4'b0000, 1'b0, "rereq_idle"); step();

    // MAX_HOLD=2 rotation with all sources requesting
    req_b = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      g = 4'b0001 << (i % 4);
      expect_out(1, g, 1'b0, $sformatf("rot%0d_a", i)); step();
      expect_out(1, g, 1'b0, $sformatf("rot%0d_b", i)); step();
      if (i < 4) begin
        expect_out(1, 4'b0000, 1'b1, $sformatf("rot%0d_turn", i)); step();
      end
    end
    req_b = 4'b0000;
    expect_out(1, 4'b0000, 1'b1, "rot_end_turn"); step();
    expect_out(1, 4'b0000, 1'b0, "rot_end_idle"); step();

    // MAX_HOLD saturation: lone requester keeps bus, released once another arrives
    req_b = 4'b0100;
    for (int i = 0; i < 6; i++) begin
      expect_out(1, 4'b0100, 1'b0, $sformatf("sat_hold%0d", i)); step();
    end
    req_b = 4'b0110;
    expect_out(1, 4'b0000, 1'b1, "sat_turn"); step();
    expect_out(1, 4'b0010, 1'b0, "sat_next"); step();
    req_b = 4'b0000;
    expect_out(1, 4'b0000, 1'b1, "sat_turn2"); step();
    expect_out(1, 4'b0000, 1'b0, "sat_idle"); step();

    // Asynchronous reset mid-drive, then source 0 has first priority
    req_a = 4'b0001;
    expect_out(0, 4'b0001, 1'b0, "arst_drv"); step();
    #2;
    rst_n  = 1'b0;
    req_a  = 4'b0000;
    last_a = '0;
    last_b = '0;
    #1;
    expect_out(0, 4'b0000, 1'b0, "arst_release");
    check_q();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    req_a = 4'b1001;
    expect_out(0, 4'b0001, 1'b0, "arst_first"); step();
    req_a = 4'b0000;
    expect_out(0, 4'b0000, 1'b1, "arst_turn"); step();
    expect_out(0, 4'b0000, 1'b0, "arst_idle"); step();

    // Random requests: grant one-hot/zero, never two owners back to back
    prev_a = grant_a;
    prev_b = grant_b;
    for (int i = 0; i < 300; i++) begin
      req_a = 4'($urandom_range(0, 15));
      req_b = 4'($urandom_range(0, 15));
      @(posedge clk);
      #1;
      cmp("rand_onehot_a", W'($onehot0(grant_a)), W'(1));
      cmp("rand_onehot_b", W'($onehot0(grant_b)), W'(1));
      cmp("rand_b2b_a", W'(prev_a != '0 && grant_a != '0 && grant_a != prev_a), W'(0));
      cmp("rand_b2b_b", W'(prev_b != '0 && grant_b != '0 && grant_b != prev_b), W'(0));
      prev_a = grant_a;
      prev_b = grant_b;
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
